stream_muxn: RTL and testbench
==============================

# stream_muxn

Parametrised, registered N-to-1 stream multiplexer with valid/ready handshake, packet locking, and selectable fixed-select or round-robin arbitration. It is the sequential successor to the combinational mux tree. It sits between several producer channels and one consumer. It guarantees that multi-beat packets are never interleaved, and that one output beat is registered per accepted input beat.

## Interface
Parameters:
- N, 32, data width per channel
- CHANNELS, 8, number of input channels (≥2, need not be a power of two)
- SEL_W, $clog2(CHANNELS), width of select/channel-id fields (derived; do not override)

Ports (clock and reset first):
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-low reset
- mode  input  1  0 = FIXED (channel chosen by s), 1 = ROUND_ROBIN
- s  input  SEL_W  channel select, used in FIXED mode only
- in_data  input  CHANNELS*N  channel c occupies bits [c*N +: N]
- in_valid  input  CHANNELS  per-channel beat valid
- in_last  input  CHANNELS  per-channel end-of-packet flag
- in_ready  output  CHANNELS  per-channel accept; at most one bit high per cycle
- out_data  output  N  registered selected data
- out_last  output  1  registered end-of-packet flag
- out_chan  output  SEL_W  source channel of the current out beat
- out_valid  output  1  output beat valid
- out_ready  input  1  consumer accept

## Operation
- Transfer on input c: in_valid[c] && in_ready[c]. Transfer on output: out_valid && out_ready.
- Output stage is a one-entry register. It can load when `space = !out_valid || out_ready`.
- Grant selection. It occurs only when unlocked.
  - FIXED: grant = s. If s ≥ CHANNELS, nothing is granted.
  - ROUND_ROBIN: grant = first c with in_valid[c], searching from (rr_ptr+1) mod CHANNELS upward with wrap.
- in_ready[g] = space && grant_valid, for the granted channel g only. All other bits are 0.
- On an input transfer:
  - Load out_data/out_last/out_chan from channel g.
  - Set out_valid=1.
  - If in_last[g]=0, set lock=1 and locked_chan=g.
  - If in_last[g]=1, set lock=0 and rr_ptr=g.
- While locked:
  - grant = locked_chan, regardless of mode, s, or other valids.
  - Changes to mode and s are ignored until the last beat transfers.
- An output transfer with no input transfer in the same cycle clears out_valid.
- A simultaneous output and input transfer replaces the register contents; out_valid stays 1 (full throughput).
- If out_valid && !out_ready, all in_ready are 0, and out_data/out_last/out_chan hold stable.
- A single-beat packet (in_last=1 on the first beat) never sets lock.

## Timing
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 beat/cycle while out_ready=1.
- in_ready is combinational from in_valid, mode, s, out_valid, out_ready, and state. No other input-to-output combinational paths exist.
- Reset (rst=0 at a clock edge):
  - out_valid=0, out_data=0, out_last=0, out_chan=0, lock=0, locked_chan=0.
  - rr_ptr=CHANNELS-1, so channel 0 has first priority.
  - in_ready=0 during the reset cycle.
- Reset mid-packet drops the lock and any held beat. Recovery of partial packets is the caller's responsibility.
- rr_ptr advances only on a last-beat transfer. It wraps from CHANNELS-1 to 0.

## Structure
- Package stream_mux_pkg holds:
  - typedef enum logic {MODE_FIXED=1'b0, MODE_RR=1'b1} mux_mode_t.
  - Any shared width constants.
- Sub-module rr_arbiter (parametrised by CHANNELS):
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and grant index/valid.
  - Purely combinational.
- Top level holds the lock state, rr_ptr, and the output register.

## Test plan
- FIXED, s=3, out_ready=1. Three-beat packet on ch3 (0xA1, 0xA2, 0xA3 with last) -> out beats appear 1 cycle later each, out_chan=3, out_last only on 0xA3.
- FIXED, lock check. Lock on ch1, then change s to 5 mid-packet -> ch5 in_ready stays 0 until ch1's last beat transfers. Ch5 is granted the next cycle.
- ROUND_ROBIN, all channels continuously valid with single-beat packets -> out_chan sequence 0,1,…,CHANNELS-1,0 with no gaps.
- Backpressure. out_ready=0 for 4 cycles with out_valid=1 -> out_data stable, all in_ready=0. out_ready=1 -> one beat per cycle resumes, no beat lost or duplicated.
- FIXED, s=CHANNELS (out of range when CHANNELS is not a power of two, e.g. 6) -> no grant, out_valid stays 0.
- Reset asserted mid-packet on ch2 -> next cycle all outputs are zero and lock=0. After release in ROUND_ROBIN with ch0 and ch2 valid -> ch0 is granted first.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared types and defaults for the registered stream multiplexer.
package stream_mux_pkg;

    typedef enum logic {MODE_FIXED = 1'b0, MODE_RR = 1'b1} mux_mode_t;

    localparam int DEF_N        = 32;
    localparam int DEF_CHANNELS = 8;

    // Channel index successor with wrap, tolerant of an index at or past the end.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned count);
        return (idx + 1 >= count) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester strictly after ptr_i, with wrap.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req_i,
    input  logic [SEL_W-1:0]    ptr_i,
    output logic [CHANNELS-1:0] grant_oh_o,
    output logic [SEL_W-1:0]    grant_idx_o,
    output logic                grant_valid_o
);

    int unsigned      idx;
    logic [SEL_W-1:0] sel;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        grant_oh_o    = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        idx           = int'(ptr_i);
        sel           = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            idx = wrap_inc(idx, CHANNELS);
            sel = SEL_W'(idx);
            if (!grant_valid_o && req_i[sel]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = sel;
            end
        end
        if (grant_valid_o) begin
            grant_oh_o[grant_idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/stream_muxn.sv
// Registered N-to-1 stream mux with packet locking and fixed or round-robin arbitration.
module stream_muxn
    import stream_mux_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      s,
    input  logic [CHANNELS*N-1:0] in_data,
    input  logic [CHANNELS-1:0]   in_valid,
    input  logic [CHANNELS-1:0]   in_last,
    output logic [CHANNELS-1:0]   in_ready,
    output logic [N-1:0]          out_data,
    output logic                  out_last,
    output logic [SEL_W-1:0]      out_chan,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam logic [SEL_W:0]   CH_COUNT  = (SEL_W + 1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST_CHAN = SEL_W'(CHANNELS - 1);

    logic [N-1:0]     out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic [SEL_W-1:0] out_chan_q, out_chan_d;
    logic             out_valid_q, out_valid_d;
    logic             lock_q, lock_d;
    logic [SEL_W-1:0] locked_chan_q, locked_chan_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [N-1:0]         chan_data [CHANNELS];
    logic [CHANNELS-1:0]  rr_grant_oh;
    logic [SEL_W-1:0]     rr_grant_idx;
    logic                 rr_grant_valid;
    logic [CHANNELS-1:0]  grant_oh;
    logic [SEL_W-1:0]     grant_idx;
    logic                 grant_valid;
    logic                 space;
    logic                 in_xfer;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        assign chan_data[c] = in_data[c*N +: N];
    end

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_rr_arbiter (
        .req_i         (in_valid),
        .ptr_i         (rr_ptr_q),
        .grant_oh_o    (rr_grant_oh),
        .grant_idx_o   (rr_grant_idx),
        .grant_valid_o (rr_grant_valid)
    );

    assign space = !out_valid_q || out_ready;

    // A held lock overrides both mode and s until the last beat of the packet goes through.
    always_comb begin
        grant_oh    = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        if (lock_q) begin
            grant_idx              = locked_chan_q;
            grant_valid            = 1'b1;
            grant_oh[locked_chan_q] = 1'b1;
        end else if (mux_mode_t'(mode) == MODE_RR) begin
            grant_idx   = rr_grant_idx;
            grant_valid = rr_grant_valid;
            grant_oh    = rr_grant_oh;
        end else if ({1'b0, s} < CH_COUNT) begin
            grant_idx   = s;
            grant_valid = 1'b1;
            grant_oh[s] = 1'b1;
        end
    end

    assign in_ready = (rst && space && grant_valid) ? grant_oh : '0;
    assign in_xfer  = |(in_ready & in_valid);

    always_comb begin
        out_data_d    = out_data_q;
        out_last_d    = out_last_q;
        out_chan_d    = out_chan_q;
        out_valid_d   = out_valid_q;
        lock_d        = lock_q;
        locked_chan_d = locked_chan_q;
        rr_ptr_d      = rr_ptr_q;
        if (in_xfer) begin
            out_data_d  = chan_data[grant_idx];
            out_last_d  = in_last[grant_idx];
            out_chan_d  = grant_idx;
            out_valid_d = 1'b1;
            if (in_last[grant_idx]) begin
                lock_d   = 1'b0;
                rr_ptr_d = grant_idx;
            end else begin
                lock_d        = 1'b1;
                locked_chan_d = grant_idx;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    // NOTE: the data register is reset too, because out_data must read zero right after reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_data_q    <= '0;
            out_last_q    <= 1'b0;
            out_chan_q    <= '0;
            out_valid_q   <= 1'b0;
            lock_q        <= 1'b0;
            locked_chan_q <= '0;
            rr_ptr_q      <= LAST_CHAN;
        end else begin
            out_data_q    <= out_data_d;
            out_last_q    <= out_last_d;
            out_chan_q    <= out_chan_d;
            out_valid_q   <= out_valid_d;
            lock_q        <= lock_d;
            locked_chan_q <= locked_chan_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_muxn.sv
// Self-checking bench for stream_muxn: directed scenarios plus random traffic against a reference model.
module tb_stream_muxn;

    localparam int N  = 32;
    localparam int CH = 6;
    localparam int SW = $clog2(CH);

    logic              clk;
    logic              rst;
    logic              mode;
    logic [SW-1:0]     s;
    logic [CH*N-1:0]   in_data;
    logic [CH-1:0]     in_valid;
    logic [CH-1:0]     in_last;
    logic [CH-1:0]     in_ready;
    logic [N-1:0]      out_data;
    logic              out_last;
    logic [SW-1:0]     out_chan;
    logic              out_valid;
    logic              out_ready;

    int checks   = 0;
    int failures = 0;

    // Reference model state: the output register contents, packet lock and round-robin pointer.
    bit          m_valid;
    logic [N-1:0] m_data;
    bit          m_last;
    int          m_chan;
    bit          m_lock;
    int          m_lchan;
    int          m_rr;

    stream_muxn #(.N(N), .CHANNELS(CH)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .s         (s),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [CH-1:0] bitv(input int c);
        logic [CH-1:0] one = 1;
        return one << c;
    endfunction

    task automatic set_data(input int c, input logic [N-1:0] v);
        in_data[c*N +: N] = v;
    endtask

    function automatic void model_grant(output bit gv, output int gi);
        gv = 0;
        gi = 0;
        if (m_lock) begin
            gv = 1;
            gi = m_lchan;
        end else if (mode == 1'b0) begin
            gv = (int'(s) < CH);
            gi = int'(s);
        end else begin
            for (int k = 1; k <= CH; k++) begin
                int c = (m_rr + k) % CH;
                if (!gv && in_valid[c]) begin
                    gv = 1;
                    gi = c;
                end
            end
        end
    endfunction

    // Inputs are set right after a falling edge; this checks in_ready, clocks, then checks outputs.
    task automatic tick(input string tag);
        bit gv, sp, xf;
        int gi;
        logic [CH-1:0] er;
        #1;
        model_grant(gv, gi);
        sp = !m_valid || out_ready;
        er = (rst && sp && gv) ? bitv(gi) : '0;
        check({tag, ".in_ready"}, 64'(in_ready), 64'(er));
        @(posedge clk);
        if (!rst) begin
            m_valid = 0; m_data = '0; m_last = 0; m_chan = 0;
            m_lock = 0; m_lchan = 0; m_rr = CH - 1;
        end else begin
            xf = gv && sp && in_valid[gi];
            if (xf) begin
                m_valid = 1;
                m_data  = in_data[gi*N +: N];
                m_last  = in_last[gi];
                m_chan  = gi;
                if (in_last[gi]) begin
                    m_lock = 0;
                    m_rr   = gi;
                end else begin
                    m_lock  = 1;
                    m_lchan = gi;
                end
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
        end
        @(negedge clk);
        check({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
        check({tag, ".out_data"},  64'(out_data),  64'(m_data));
        check({tag, ".out_chan"},  64'(out_chan),  64'(m_chan));
        check({tag, ".out_last"},  64'(out_last),  64'(m_last));
    endtask

    initial begin
        logic [N-1:0] hold;
        rst = 1'b0; mode = 1'b0; s = '0; in_data = '0;
        in_valid = '0; in_last = '0; out_ready = 1'b1;
        m_valid = 0; m_data = '0; m_last = 0; m_chan = 0;
        m_lock = 0; m_lchan = 0; m_rr = CH - 1;
        @(negedge clk);

        // Reset state, with a request present to show in_ready stays low.
        in_valid = bitv(0);
        tick("reset0");
        tick("reset1");
        check("reset.out_valid", 64'(out_valid), 64'(0));
        check("reset.out_data",  64'(out_data),  64'(0));
        rst = 1'b1;
        in_valid = '0;

        // FIXED s=3: three-beat packet, last only on the third beat.
        s = 3'd3;
        for (int i = 0; i < 3; i++) begin
            in_valid = bitv(3);
            in_last  = (i == 2) ? bitv(3) : '0;
            set_data(3, 32'hA1 + 32'(i));
            tick("fix3");
            check("fix3.data", 64'(out_data), 64'(32'hA1 + 32'(i)));
            check("fix3.chan", 64'(out_chan), 64'(3));
            check("fix3.last", 64'(out_last), 64'(i == 2));
        end

        // Lock on ch1, then move s to 5 mid-packet.
        s = 3'd1; in_valid = bitv(1); in_last = '0; set_data(1, 32'hB1);
        tick("lock1");
        s = 3'd5; in_valid = bitv(1) | bitv(5); in_last = bitv(5);
        set_data(1, 32'hB2); set_data(5, 32'hC1);
        #1 check("lock.hold", 64'(in_ready), 64'(bitv(1)));
        tick("lock2");
        in_last = bitv(1) | bitv(5); set_data(1, 32'hB3);
        #1 check("lock.hold_last", 64'(in_ready), 64'(bitv(1)));
        tick("lock3");
        check("lock.last_chan", 64'(out_chan), 64'(1));
        check("lock.last_flag", 64'(out_last), 64'(1));
        in_valid = bitv(5);
        #1 check("lock.release", 64'(in_ready), 64'(bitv(5)));
        tick("lock4");
        check("lock.ch5_chan", 64'(out_chan), 64'(5));
        check("lock.ch5_data", 64'(out_data), 64'(32'hC1));

        // ROUND_ROBIN with every channel valid and single-beat packets.
        mode = 1'b1; in_valid = '1; in_last = '1;
        for (int i = 0; i <= CH; i++) begin
            for (int c = 0; c < CH; c++) set_data(c, {8'(c), 24'(i)});
            tick("rr");
            check("rr.seq_chan", 64'(out_chan), 64'(i % CH));
            check("rr.seq_valid", 64'(out_valid), 64'(1));
        end

        // Backpressure: output must hold while out_ready is low.
        hold = {8'd0, 24'(CH)};
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < CH; c++) set_data(c, {8'(c), 24'(100 + i)});
            #1 check("bp.in_ready", 64'(in_ready), 64'(0));
            tick("bp");
            check("bp.stable", 64'(out_data), 64'(hold));
        end
        out_ready = 1'b1;
        for (int i = 0; i < CH; i++) begin
            for (int c = 0; c < CH; c++) set_data(c, {8'(c), 24'(200 + i)});
            tick("bp_resume");
            check("bp.resume_chan", 64'(out_chan), 64'((i + 1) % CH));
            check("bp.resume_data", 64'(out_data), 64'({8'((i + 1) % CH), 24'(200 + i)}));
        end

        // FIXED with s out of range: nothing is ever granted.
        in_valid = '0;
        tick("drain");
        mode = 1'b0; s = SW'(CH); in_valid = '1;
        for (int i = 0; i < 3; i++) begin
            tick("oor");
            check("oor.out_valid", 64'(out_valid), 64'(0));
        end

        // Reset mid-packet on ch2, then round-robin restarts from ch0.
        s = 3'd2; in_valid = bitv(2); in_last = '0; set_data(2, 32'hD1);
        tick("midpkt");
        rst = 1'b0;
        tick("midrst");
        check("midrst.valid", 64'(out_valid), 64'(0));
        check("midrst.data",  64'(out_data),  64'(0));
        check("midrst.chan",  64'(out_chan),  64'(0));
        check("midrst.last",  64'(out_last),  64'(0));
        rst = 1'b1; mode = 1'b1; in_valid = bitv(0) | bitv(2); in_last = '1;
        set_data(0, 32'hE0); set_data(2, 32'hE2);
        #1 check("postrst.ready", 64'(in_ready), 64'(bitv(0)));
        tick("postrst");
        check("postrst.chan", 64'(out_chan), 64'(0));

        // Random traffic against the model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst = ($urandom_range(0, 99) != 0);
            if (cyc % 50 == 0) mode = 1'($urandom);
            s         = SW'($urandom_range(0, 7));
            in_valid  = CH'($urandom);
            in_last   = CH'($urandom & $urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < CH; c++) set_data(c, N'($urandom));
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
